// File: rtl/au_div_seq.sv
// Iterative RV32M DIV/DIVU/REM/REMU sequencer driving a shared external add/sub unit.
// Latency: 35 clocks from accept edge to resp_valid, or the next cycle for fast special cases.
// Backpressure: req_ready only when idle; result held in DONE until resp_ready.
module au_div_seq #(
    parameter bit FAST_SPECIAL = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_op,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_data,
    output logic        busy,
    output logic [31:0] au_ra,
    output logic [31:0] au_rb,
    output logic        au_mode,
    input  logic [31:0] au_out,
    input  logic        au_unsigned_compare
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_NEG_A,
        S_NEG_B,
        S_DIV,
        S_FIX,
        S_DONE
    } state_t;

    state_t      state, state_nxt;

    logic        is_rem_q;
    logic        a_neg_q;
    logic        b_neg_q;
    logic        div0_q;
    logic [4:0]  cnt_q;
    logic [31:0] quo_q;     // dividend magnitude, shifted into the quotient
    logic [31:0] b_q;
    logic [31:0] rem_q;
    logic [31:0] res_q;

    logic        accept;
    logic        req_div0;
    logic        req_ovf;
    logic        req_special;
    logic [31:0] special_res;
    logic [31:0] sh;
    logic        take;
    logic [31:0] fix_res;
    logic        fix_neg;

    assign req_ready  = (state == S_IDLE);
    assign busy       = (state != S_IDLE);
    assign resp_valid = (state == S_DONE);
    assign resp_data  = res_q;

    assign accept      = req_valid && req_ready && !flush;
    assign req_div0    = (req_b == 32'd0);
    assign req_ovf     = !req_op[0] && (req_a == 32'h8000_0000) && (req_b == 32'hFFFF_FFFF);
    assign req_special = req_div0 || req_ovf;

    always_comb begin
        special_res = 32'd0;
        if (req_div0)
            special_res = req_op[1] ? req_a : 32'hFFFF_FFFF;
        else
            special_res = req_op[1] ? 32'd0 : 32'h8000_0000;
    end

    // rem_q[31] is the 33rd bit of the shifted remainder: when set, it always exceeds b.
    assign sh   = {rem_q[30:0], quo_q[31]};
    assign take = rem_q[31] | ~au_unsigned_compare;

    // A divide-by-zero quotient is all ones regardless of operand signs.
    assign fix_res = is_rem_q ? rem_q : quo_q;
    assign fix_neg = is_rem_q ? a_neg_q : ((a_neg_q ^ b_neg_q) & ~div0_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        au_mode   = 1'b0;
        au_ra     = 32'd0;
        au_rb     = 32'd0;
        case (state)
            S_IDLE: begin
                if (accept)
                    state_nxt = (FAST_SPECIAL && req_special) ? S_DONE : S_NEG_A;
            end
            S_NEG_A: begin
                au_mode   = 1'b1;
                au_rb     = quo_q;
                state_nxt = S_NEG_B;
            end
            S_NEG_B: begin
                au_mode   = 1'b1;
                au_rb     = b_q;
                state_nxt = S_DIV;
            end
            S_DIV: begin
                au_mode = 1'b1;
                au_ra   = sh;
                au_rb   = b_q;
                if (cnt_q == 5'd31)
                    state_nxt = S_FIX;
            end
            S_FIX: begin
                if (fix_neg) begin
                    au_mode = 1'b1;
                    au_rb   = fix_res;
                end
                state_nxt = S_DONE;
            end
            S_DONE: begin
                if (resp_ready)
                    state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
        if (flush)
            state_nxt = S_IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            is_rem_q <= 1'b0;
            a_neg_q  <= 1'b0;
            b_neg_q  <= 1'b0;
            div0_q   <= 1'b0;
            cnt_q    <= 5'd0;
            quo_q    <= 32'd0;
            b_q      <= 32'd0;
            rem_q    <= 32'd0;
            res_q    <= 32'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        is_rem_q <= req_op[1];
                        a_neg_q  <= !req_op[0] && req_a[31];
                        b_neg_q  <= !req_op[0] && req_b[31];
                        div0_q   <= req_div0;
                        cnt_q    <= 5'd0;
                        quo_q    <= req_a;
                        b_q      <= req_b;
                        rem_q    <= 32'd0;
                        if (FAST_SPECIAL && req_special)
                            res_q <= special_res;
                    end
                end
                S_NEG_A: begin
                    if (a_neg_q)
                        quo_q <= au_out;
                end
                S_NEG_B: begin
                    if (b_neg_q)
                        b_q <= au_out;
                end
                S_DIV: begin
                    rem_q <= take ? au_out : sh;
                    quo_q <= {quo_q[30:0], take};
                    cnt_q <= cnt_q + 5'd1;
                end
                S_FIX: begin
                    if (!flush)
                        res_q <= fix_neg ? au_out : fix_res;
                end
                default: ;
            endcase
        end
    end

endmodule
